// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement of out-of-order results, tags 1..2^ROB_TAG_W-1.
// Ports: clk, rst, rdy, in_flush, alloc (in_alloc_*/out_alloc_tag/out_full),
//   CDB (in_cdb_*), two operand queries (in_query_tag*/out_query_*), commit (out_commit_*).
// Optional macro ROB_CDB_BYPASS_EN forwards a same-cycle CDB result onto the query ports.
module reorder_buffer #(
    parameter int ROB_TAG_W = 4,
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 in_flush,
    input  logic                 in_alloc_valid,
    input  logic [REG_W-1:0]     in_alloc_dest_reg,
    output logic [ROB_TAG_W-1:0] out_alloc_tag,
    output logic                 out_full,
    input  logic                 in_cdb_valid,
    input  logic [ROB_TAG_W-1:0] in_cdb_tag,
    input  logic [DATA_W-1:0]    in_cdb_value,
    input  logic [ROB_TAG_W-1:0] in_query_tag1,
    input  logic [ROB_TAG_W-1:0] in_query_tag2,
    output logic                 out_query_ready1,
    output logic                 out_query_ready2,
    output logic [DATA_W-1:0]    out_query_value1,
    output logic [DATA_W-1:0]    out_query_value2,
    output logic [REG_W-1:0]     out_commit_reg,
    output logic [ROB_TAG_W-1:0] out_commit_tag,
    output logic [DATA_W-1:0]    out_commit_value
);

    localparam int NENT = 1 << ROB_TAG_W;
    localparam logic [ROB_TAG_W-1:0] MAXTAG = ROB_TAG_W'(NENT - 1);
    localparam logic [ROB_TAG_W-1:0] TAG1   = ROB_TAG_W'(1);

    // Slot 0 exists only so tags index directly; it is never made busy.
    logic [NENT-1:0]      busy_q, busy_d;
    logic [NENT-1:0]      ready_q, ready_d;
    logic [REG_W-1:0]     dest_q [NENT];
    logic [REG_W-1:0]     dest_d [NENT];
    logic [DATA_W-1:0]    val_q [NENT];
    logic [DATA_W-1:0]    val_d [NENT];
    logic [ROB_TAG_W-1:0] head_q, head_d;
    logic [ROB_TAG_W-1:0] tail_q, tail_d;
    logic [ROB_TAG_W-1:0] count_q, count_d;

    logic cdb_hit, commit_ok, do_alloc;
    logic byp1, byp2, hit1, hit2;

    function automatic logic [ROB_TAG_W-1:0] nxt(input logic [ROB_TAG_W-1:0] p);
        return (p == MAXTAG) ? TAG1 : p + TAG1;
    endfunction

    assign out_full      = (count_q == MAXTAG);
    assign out_alloc_tag = tail_q;
    assign cdb_hit   = in_cdb_valid && (in_cdb_tag != '0) && busy_q[in_cdb_tag];
    assign commit_ok = (count_q != '0) && ready_q[head_q];
    // Allocation looks at the pre-edge full flag, so a same-cycle commit never frees room.
    assign do_alloc  = in_alloc_valid && !out_full;

    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        dest_d  = dest_q;
        val_d   = val_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (in_flush) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = TAG1;
            tail_d  = TAG1;
            count_d = '0;
        end else begin
            if (cdb_hit) begin
                ready_d[in_cdb_tag] = 1'b1;
                val_d[in_cdb_tag]   = in_cdb_value;
            end
            if (commit_ok) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = nxt(head_q);
            end
            // Tail is never busy when allocation is allowed, so no clash with CDB/commit.
            if (do_alloc) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = 1'b0;
                dest_d[tail_q]  = in_alloc_dest_reg;
                tail_d          = nxt(tail_q);
            end
            case ({do_alloc, commit_ok})
                2'b10:   count_d = count_q + TAG1;
                2'b01:   count_d = count_q - TAG1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            ready_q <= '0;
            head_q  <= TAG1;
            tail_q  <= TAG1;
            count_q <= '0;
            for (int i = 0; i < NENT; i++) begin
                dest_q[i] <= '0;
                val_q[i]  <= '0;
            end
        end else if (rdy) begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dest_q  <= dest_d;
            val_q   <= val_d;
        end
    end

    always_comb begin
        out_commit_reg   = '0;
        out_commit_tag   = '0;
        out_commit_value = '0;
        if (commit_ok) begin
            out_commit_reg   = dest_q[head_q];
            out_commit_tag   = head_q;
            out_commit_value = val_q[head_q];
        end
    end

    assign hit1 = (in_query_tag1 != '0) && busy_q[in_query_tag1] && ready_q[in_query_tag1];
    assign hit2 = (in_query_tag2 != '0) && busy_q[in_query_tag2] && ready_q[in_query_tag2];

`ifdef ROB_CDB_BYPASS_EN
    assign byp1 = in_cdb_valid && (in_query_tag1 != '0) && (in_cdb_tag == in_query_tag1)
                  && busy_q[in_query_tag1];
    assign byp2 = in_cdb_valid && (in_query_tag2 != '0) && (in_cdb_tag == in_query_tag2)
                  && busy_q[in_query_tag2];
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // Bypassed CDB data wins: it is newer than anything already stored.
    always_comb begin
        out_query_ready1 = 1'b0;
        out_query_value1 = '0;
        out_query_ready2 = 1'b0;
        out_query_value2 = '0;
        if (byp1) begin
            out_query_ready1 = 1'b1;
            out_query_value1 = in_cdb_value;
        end else if (hit1) begin
            out_query_ready1 = 1'b1;
            out_query_value1 = val_q[in_query_tag1];
        end
        if (byp2) begin
            out_query_ready2 = 1'b1;
            out_query_value2 = in_cdb_value;
        end else if (hit2) begin
            out_query_ready2 = 1'b1;
            out_query_value2 = val_q[in_query_tag2];
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios plus random traffic
// checked against a queue-based program-order model.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy, in_flush;
    logic        in_alloc_valid;
    logic [4:0]  in_alloc_dest_reg;
    logic [3:0]  out_alloc_tag;
    logic        out_full;
    logic        in_cdb_valid;
    logic [3:0]  in_cdb_tag;
    logic [31:0] in_cdb_value;
    logic [3:0]  in_query_tag1, in_query_tag2;
    logic        out_query_ready1, out_query_ready2;
    logic [31:0] out_query_value1, out_query_value2;
    logic [4:0]  out_commit_reg;
    logic [3:0]  out_commit_tag;
    logic [31:0] out_commit_value;

    int checks = 0;
    int errors = 0;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_flush(in_flush),
        .in_alloc_valid(in_alloc_valid), .in_alloc_dest_reg(in_alloc_dest_reg),
        .out_alloc_tag(out_alloc_tag), .out_full(out_full),
        .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag),
        .in_cdb_value(in_cdb_value),
        .in_query_tag1(in_query_tag1), .in_query_tag2(in_query_tag2),
        .out_query_ready1(out_query_ready1), .out_query_ready2(out_query_ready2),
        .out_query_value1(out_query_value1), .out_query_value2(out_query_value2),
        .out_commit_reg(out_commit_reg), .out_commit_tag(out_commit_tag),
        .out_commit_value(out_commit_value)
    );

    always #5 clk = ~clk;

    // Model: entries in program order; next_tag is the tag the next allocation gets.
    typedef struct {
        int          tag;
        int          dest;
        bit          rdy;
        logic [31:0] val;
    } ent_t;

    ent_t mq[$];
    int   next_tag;

    function automatic int find(input int t);
        if (t == 0) return -1;
        foreach (mq[i]) if (mq[i].tag == t) return i;
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete();
        next_tag = 1;
    endtask

    task automatic model_step();
        bit commit;
        int k;
        if (in_flush) begin
            model_reset();
            return;
        end
        commit = (mq.size() > 0) && mq[0].rdy;
        if (in_cdb_valid) begin
            k = find(int'(in_cdb_tag));
            if (k >= 0) begin
                mq[k].rdy = 1'b1;
                mq[k].val = in_cdb_value;
            end
        end
        if (commit) void'(mq.pop_front());
        if (in_alloc_valid && (mq.size() + (commit ? 1 : 0)) < 15) begin
            mq.push_back('{tag: next_tag, dest: int'(in_alloc_dest_reg), rdy: 1'b0, val: 32'h0});
            next_tag = (next_tag == 15) ? 1 : next_tag + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic qexp(input int t, output logic r, output logic [31:0] v);
        int k;
        k = find(t);
        r = 1'b0;
        v = 32'h0;
        if (k < 0) return;
`ifdef ROB_CDB_BYPASS_EN
        if (in_cdb_valid && int'(in_cdb_tag) == t) begin
            r = 1'b1;
            v = in_cdb_value;
            return;
        end
`endif
        if (mq[k].rdy) begin
            r = 1'b1;
            v = mq[k].val;
        end
    endtask

    task automatic check_all(input string tag);
        logic        r;
        logic [31:0] v;
        int          er = 0, et = 0;
        logic [31:0] ev = 0;
        if (mq.size() > 0 && mq[0].rdy) begin
            er = mq[0].dest;
            et = mq[0].tag;
            ev = mq[0].val;
        end
        chk({tag, "_creg"}, 64'(out_commit_reg), 64'(er));
        chk({tag, "_ctag"}, 64'(out_commit_tag), 64'(et));
        chk({tag, "_cval"}, 64'(out_commit_value), 64'(ev));
        chk({tag, "_full"}, 64'(out_full), 64'(mq.size() == 15));
        chk({tag, "_atag"}, 64'(out_alloc_tag), 64'(next_tag));
        qexp(int'(in_query_tag1), r, v);
        chk({tag, "_qr1"}, 64'(out_query_ready1), 64'(r));
        chk({tag, "_qv1"}, 64'(out_query_value1), 64'(v));
        qexp(int'(in_query_tag2), r, v);
        chk({tag, "_qr2"}, 64'(out_query_ready2), 64'(r));
        chk({tag, "_qv2"}, 64'(out_query_value2), 64'(v));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        if (rdy) model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        rdy               = 1'b1;
        in_flush          = 1'b0;
        in_alloc_valid    = 1'b0;
        in_alloc_dest_reg = 5'd0;
        in_cdb_valid      = 1'b0;
        in_cdb_tag        = 4'd0;
        in_cdb_value      = 32'h0;
        in_query_tag1     = 4'd0;
        in_query_tag2     = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic alloc(input int dest);
        idle();
        in_alloc_valid    = 1'b1;
        in_alloc_dest_reg = 5'(dest);
        cycle("alloc");
    endtask

    task automatic cdb(input int t, input logic [31:0] v);
        idle();
        in_cdb_valid = 1'b1;
        in_cdb_tag   = 4'(t);
        in_cdb_value = v;
        cycle("cdb");
    endtask

    initial begin
        int k;
        idle();
        rst = 1'b0;
        model_reset();

        // Reset values
        do_reset();
        #1;
        chk("rst_atag", 64'(out_alloc_tag), 64'd1);
        chk("rst_full", 64'(out_full), 64'd0);
        chk("rst_ctag", 64'(out_commit_tag), 64'd0);
        chk("rst_qr1", 64'(out_query_ready1), 64'd0);
        cycle("rst");

        // Fill to 15 entries, then a refused 16th request
        for (int i = 0; i < 15; i++) alloc(i + 1);
        #1;
        chk("fill_full", 64'(out_full), 64'd1);
        chk("fill_atag", 64'(out_alloc_tag), 64'd1);
        alloc(9);
        chk("fill16_full", 64'(out_full), 64'd1);

        // Full with ready head: commit happens, allocation refused
        cdb(1, 32'h1111);
        idle();
        in_alloc_valid = 1'b1;
        in_alloc_dest_reg = 5'd7;
        #1;
        chk("fullc_ctag", 64'(out_commit_tag), 64'd1);
        cycle("fullc");
        idle();
        #1;
        chk("fullc_full", 64'(out_full), 64'd0);
        chk("fullc_cnt", 64'(mq.size()), 64'd14);
        chk("fullc_atag", 64'(out_alloc_tag), 64'd1);
        cycle("fullc2");

        // Out-of-order completion retires in order
        do_reset();
        alloc(5);
        alloc(6);
        cdb(2, 32'hB);
        idle();
        #1;
        chk("ord_nocommit", 64'(out_commit_tag), 64'd0);
        cdb(1, 32'hA);
        idle();
        #1;
        chk("ord_first_reg", 64'(out_commit_reg), 64'd5);
        chk("ord_first_val", 64'(out_commit_value), 64'hA);
        cycle("ord1");
        #1;
        chk("ord_second_reg", 64'(out_commit_reg), 64'd6);
        chk("ord_second_val", 64'(out_commit_value), 64'hB);
        cycle("ord2");

        // dest_reg 0 still retires
        alloc(0);
        cdb(3, 32'h33);
        idle();
        #1;
        chk("x0_ctag", 64'(out_commit_tag), 64'd3);
        chk("x0_creg", 64'(out_commit_reg), 64'd0);
        cycle("x0");

        // Query with same-cycle CDB write
        do_reset();
        alloc(1);
        alloc(2);
        alloc(3);
        idle();
        in_query_tag1 = 4'd3;
        in_cdb_valid  = 1'b1;
        in_cdb_tag    = 4'd3;
        in_cdb_value  = 32'h55;
        #1;
`ifdef ROB_CDB_BYPASS_EN
        chk("byp_rdy", 64'(out_query_ready1), 64'd1);
        chk("byp_val", 64'(out_query_value1), 64'h55);
`else
        chk("byp_rdy", 64'(out_query_ready1), 64'd0);
`endif
        cycle("byp");
        idle();
        in_query_tag1 = 4'd3;
        in_query_tag2 = 4'd0;
        #1;
        chk("byp_next_rdy", 64'(out_query_ready1), 64'd1);
        chk("byp_next_val", 64'(out_query_value1), 64'h55);
        chk("q0_rdy", 64'(out_query_ready2), 64'd0);
        cycle("byp2");

        // rdy=0 freezes state
        cdb(1, 32'h77);
        idle();
        rdy = 1'b0;
        in_alloc_valid = 1'b1;
        cycle("frz1");
        cycle("frz2");
        idle();
        #1;
        chk("frz_ctag", 64'(out_commit_tag), 64'd1);
        chk("frz_atag", 64'(out_alloc_tag), 64'd4);
        cycle("frz3");

        // Flush beats alloc, CDB and a ready head
        cdb(2, 32'h22);
        idle();
        in_flush = 1'b1;
        in_alloc_valid = 1'b1;
        in_cdb_valid = 1'b1;
        in_cdb_tag = 4'd3;
        cycle("flush");
        idle();
        #1;
        chk("flush_ctag", 64'(out_commit_tag), 64'd0);
        chk("flush_atag", 64'(out_alloc_tag), 64'd1);
        chk("flush_cnt", 64'(mq.size()), 64'd0);
        cycle("flush2");

        // Asynchronous reset mid-operation
        for (int i = 0; i < 4; i++) alloc(i + 10);
        cdb(1, 32'h99);
        idle();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_atag", 64'(out_alloc_tag), 64'd1);
        chk("arst_ctag", 64'(out_commit_tag), 64'd0);
        chk("arst_creg", 64'(out_commit_reg), 64'd0);
        chk("arst_full", 64'(out_full), 64'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        cycle("arst1");
        cycle("arst2");

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            idle();
            rdy = ($urandom_range(9) != 0);
            in_flush = ($urandom_range(49) == 0);
            in_alloc_valid = ($urandom_range(9) < 6);
            in_alloc_dest_reg = 5'($urandom);
            in_cdb_valid = $urandom_range(1);
            in_cdb_value = $urandom;
            if (mq.size() > 0 && $urandom_range(3) != 0) begin
                k = $urandom_range(mq.size() - 1);
                in_cdb_tag = 4'(mq[k].tag);
            end else begin
                in_cdb_tag = 4'($urandom);
            end
            if (mq.size() > 0 && $urandom_range(1) == 1) begin
                k = $urandom_range(mq.size() - 1);
                in_query_tag1 = 4'(mq[k].tag);
            end else begin
                in_query_tag1 = 4'($urandom);
            end
            in_query_tag2 = $urandom_range(1) ? in_cdb_tag : 4'($urandom);
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_TAG_W, default 4, the tag width; depth is 2^ROB_TAG_W-1 entries, with tag 0 reserved as "no producer".
REQ-002 SHALL have parameter DATA_W, default 32, the result value width.
REQ-003 SHALL have parameter REG_W, default 5, the architectural register index width.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rdy  input  1  global ready; when low, all state is held.
REQ-007 in_alloc_valid  input  1  decoder requests one entry this cycle.
REQ-008 in_alloc_dest_reg  input  REG_W  destination register; 0 means no register write.
REQ-009 out_alloc_tag  output  ROB_TAG_W  tag the next allocation receives (the tail pointer).
REQ-010 out_full  output  1  buffer holds 2^ROB_TAG_W-1 entries.
REQ-011 in_cdb_valid / in_cdb_tag / in_cdb_value  input  1 / ROB_TAG_W / DATA_W  result broadcast.
REQ-012 in_query_tag1, in_query_tag2  input  ROB_TAG_W  decoder operand tags to look up.
REQ-013 out_query_ready1/2, out_query_value1/2  output  1 / DATA_W  entry already holds its result, and that result.
REQ-014 out_commit_reg / out_commit_tag / out_commit_value  output  REG_W / ROB_TAG_W / DATA_W  retirement write to the register file; reg 0 means no write.

Function
REQ-015 SHALL hold per entry: busy, ready, dest_reg and value; SHALL keep head, tail and count registers.
REQ-016 Tags SHALL run 1..2^ROB_TAG_W-1; the pointer after the maximum tag wraps to 1, never to 0.
REQ-017 Allocation occurs at an edge where rdy=1, in_alloc_valid=1 and out_full=0.
REQ-018 On allocation: entry[tail] becomes busy=1, ready=0, dest_reg=in_alloc_dest_reg; tail advances.
REQ-019 in_alloc_valid with out_full=1 SHALL be ignored, even if a commit happens the same cycle; the decoder holds the request.
REQ-020 A CDB write with a busy entry matching in_cdb_tag SHALL set that entry's ready=1 and value=in_cdb_value at the edge.
REQ-021 A CDB write with tag 0 or a non-busy tag SHALL be ignored.
REQ-022 The commit ports SHALL be combinational from state.
REQ-023 When count>0 and entry[head].ready=1: out_commit_reg=dest_reg, out_commit_tag=head, out_commit_value=value, and head pops at the next enabled edge.
REQ-024 Otherwise out_commit_reg=0, out_commit_tag=0 and out_commit_value=0.
REQ-025 Commit latency SHALL be: CDB write at edge N makes the commit visible in cycle N+1 if that entry is head; it pops at edge N+1.
REQ-026 An entry with dest_reg=0 SHALL pop while driving out_commit_reg=0.
REQ-027 At most one commit and one allocation SHALL occur per cycle.
REQ-028 Allocation and commit in the same cycle SHALL leave count unchanged.
REQ-029 out_query_readyN=1 iff entry[tag] is busy and ready, with out_query_valueN=entry value; otherwise ready=0 and value=0; tag 0 SHALL always return ready=0.
REQ-030 in_flush input 1: at an enabled edge it clears all busy bits and sets head=tail=1 and count=0.
REQ-031 in_flush SHALL take priority over a simultaneous allocation, CDB write or commit, none of which takes effect.
REQ-032 rdy=0 SHALL freeze all state; the combinational outputs continue to reflect the frozen state.

Reset
REQ-033 rst=1 SHALL asynchronously clear all busy/ready bits and set head=tail=1 and count=0.
REQ-034 Reset SHALL drive: out_alloc_tag=1, out_full=0, out_commit_reg=0, out_commit_tag=0, out_commit_value=0, out_query_ready1/2=0.
REQ-035 Reset asserted mid-operation SHALL discard all entries with no commit issued.

Configuration
REQ-036 Macro ROB_CDB_BYPASS_EN, when defined: in_cdb_valid=1 with in_cdb_tag equal to a busy query tag SHALL make out_query_readyN=1 and out_query_valueN=in_cdb_value in that same cycle.
REQ-037 Without ROB_CDB_BYPASS_EN: query ports SHALL reflect only stored state; the CDB value becomes visible the cycle after the write.

Verification
REQ-038 Reset, then allocate 15 entries with no commits -> out_full=1 after edge 15; a 16th request is ignored; out_alloc_tag=1 (wrapped).
REQ-039 Allocate tags 1,2 (dest x5, x6); CDB tag 2=0xB then tag 1=0xA -> commits x5=0xA, then x6=0xB, in order; tag 2 is never committed first.
REQ-040 Full buffer, head ready, in_alloc_valid=1 -> head commits; the allocation is refused that cycle; count becomes 14.
REQ-041 Entry tag 3 busy, query tag 3 while CDB writes tag 3=0x55 -> ready=1/0x55 the same cycle with ROB_CDB_BYPASS_EN; ready=0 then 1 the next cycle without it.
REQ-042 Flush asserted together with alloc, CDB write and a ready head -> no commit; count=0; out_alloc_tag=1.
REQ-043 rst pulsed between clock edges with 4 entries live -> outputs take reset values immediately; no commit appears afterwards.
